// File: rtl/bus_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin system bus arbiter.
package bus_arb_pkg;

    localparam int unsigned DEF_NUM_MASTERS    = 4;
    localparam int unsigned DEF_AWIDTH         = 32;
    localparam int unsigned DEF_BLWIDTH        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned MAX_BLWIDTH        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    // A zero-length burst still moves one beat.
    function automatic logic [MAX_BLWIDTH-1:0] burst_beats(input logic [MAX_BLWIDTH-1:0] len);
        return (len == '0) ? MAX_BLWIDTH'(1) : len;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or after ptr, cyclically.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IW-1:0]      idx_c,
    output logic               valid_c
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IW'((32'(ptr) + i) % NUM_REQ);
            if (!valid_c && req[cand]) begin
                valid_c       = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system bus between NUM_MASTERS masters.
// Optional stall timeout abort is built when ARB_TIMEOUT_EN is defined.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter int unsigned AWIDTH         = DEF_AWIDTH,
    parameter int unsigned BLWIDTH        = DEF_BLWIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         m_req,
    input  logic [NUM_MASTERS-1:0]         m_write,
    input  logic [NUM_MASTERS*BLWIDTH-1:0] m_burst_len,
    input  logic [NUM_MASTERS*AWIDTH-1:0]  m_addr,
    output logic [NUM_MASTERS-1:0]         m_ack,
    output logic                           s_req,
    output logic                           s_write,
    output logic [BLWIDTH-1:0]             s_burst_len,
    output logic [AWIDTH-1:0]              s_addr,
    input  logic                           s_ack,
    input  logic                           s_wait,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           busy,
    output logic                           err
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || BLWIDTH < 1 || BLWIDTH > MAX_BLWIDTH ||
        AWIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("bus_arbiter: unsupported parameter set");
    end

    arb_state_t               state_q, state_d;
    logic [NUM_MASTERS-1:0]   ack_q, ack_d;
    logic                     sreq_q, sreq_d;
    logic                     swrite_q, swrite_d;
    logic [BLWIDTH-1:0]       slen_q, slen_d;
    logic [AWIDTH-1:0]        saddr_q, saddr_d;
    logic [IW-1:0]            owner_q, owner_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic [BLWIDTH-1:0]       beat_q, beat_d;
    logic [IW-1:0]            rr_q, rr_d;

    logic [NUM_MASTERS-1:0]   pick_grant_c;
    logic [IW-1:0]            pick_idx_c;
    logic                     pick_valid_c;

    logic [AWIDTH-1:0]        addr_arr [NUM_MASTERS];
    logic [BLWIDTH-1:0]       len_arr  [NUM_MASTERS];
    logic [BLWIDTH-1:0]       sel_len_c;
    logic                     end_tenure_c;
    logic                     stall_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0]       stall_q, stall_d;
`endif

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign addr_arr[g] = m_addr[g*AWIDTH +: AWIDTH];
        assign len_arr[g]  = m_burst_len[g*BLWIDTH +: BLWIDTH];
    end

    assign sel_len_c = len_arr[pick_idx_c];

    rr_picker #(
        .NUM_REQ (NUM_MASTERS),
        .IW      (IW)
    ) u_picker (
        .req     (m_req),
        .ptr     (rr_q),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        sreq_d       = sreq_q;
        swrite_d     = swrite_q;
        slen_d       = slen_q;
        saddr_d      = saddr_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        err_d        = 1'b0;
        beat_d       = beat_q;
        rr_d         = rr_q;
        end_tenure_c = 1'b0;
        stall_c      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        stall_d      = stall_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d  = ADDR;
                    ack_d    = pick_grant_c;
                    sreq_d   = 1'b1;
                    busy_d   = 1'b1;
                    owner_d  = pick_idx_c;
                    swrite_d = m_write[pick_idx_c];
                    slen_d   = sel_len_c;
                    saddr_d  = addr_arr[pick_idx_c];
                    beat_d   = BLWIDTH'(burst_beats(MAX_BLWIDTH'(sel_len_c)));
`ifdef ARB_TIMEOUT_EN
                    stall_d  = '0;
`endif
                end
            end
            ADDR: begin
                if (s_ack) begin
                    state_d = DATA;
                end else begin
                    stall_c = 1'b1;
                end
            end
            DATA: begin
                if (!s_wait) begin
`ifdef ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (beat_q == BLWIDTH'(1)) begin
                        end_tenure_c = 1'b1;
                    end else begin
                        beat_d = beat_q - BLWIDTH'(1);
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        if (stall_c) begin
            if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                end_tenure_c = 1'b1;
                err_d        = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
`endif

        // Release the bus and hand priority to the master after the owner.
        if (end_tenure_c) begin
            state_d = TURN;
            ack_d   = '0;
            sreq_d  = 1'b0;
            busy_d  = 1'b0;
            owner_d = '0;
            beat_d  = '0;
            rr_d    = (32'(owner_q) == NUM_MASTERS - 1) ? '0 : owner_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            sreq_q   <= 1'b0;
            swrite_q <= 1'b0;
            slen_q   <= '0;
            saddr_q  <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= '0;
            rr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            sreq_q   <= sreq_d;
            swrite_q <= swrite_d;
            slen_q   <= slen_d;
            saddr_q  <= saddr_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            rr_q     <= rr_d;
`ifdef ARB_TIMEOUT_EN
            stall_q  <= stall_d;
`endif
        end
    end

    assign m_ack       = ack_q;
    assign s_req       = sreq_q;
    assign s_write     = swrite_q;
    assign s_burst_len = slen_q;
    assign s_addr      = saddr_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single system bus (address, write strobe, burst length, request/ack/wait handshake) between up to NUM_MASTERS bus masters: the mips CPU bus interface, DMA and the video fetch unit. It sits between the masters and the memory/peripheral slave side. It grants one master at a time and forwards the granted master's command to the slave. It holds the grant until the requested number of data beats has completed. It never touches bus_data; the granted master alone drives or samples it.

## Interface
- NUM_MASTERS, 4, number of requesters (2..8)
- AWIDTH, 32, address width
- BLWIDTH, 4, burst-length field width
- TIMEOUT_CYCLES, 255, wait-stall limit (used only with ARB_TIMEOUT_EN)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- m_req  in  NUM_MASTERS  per-master request, held until its m_ack falls
- m_write  in  NUM_MASTERS  per-master write (1) / read (0)
- m_burst_len  in  NUM_MASTERS*BLWIDTH  beats requested; 0 is treated as 1
- m_addr  in  NUM_MASTERS*AWIDTH  per-master start address
- m_ack  out  NUM_MASTERS  one-hot grant, high for the whole tenure
- s_req  out  1  command valid to slave
- s_write, s_burst_len, s_addr  out  1/BLWIDTH/AWIDTH  granted master's command, registered at grant
- s_ack  in  1  slave accepted command
- s_wait  in  1  slave not ready this cycle; beat completes when low during DATA
- owner  out  $clog2(NUM_MASTERS)  index of granted master (0 when idle)
- busy  out  1  tenure in progress
- err  out  1  one-cycle timeout abort pulse (0 without ARB_TIMEOUT_EN)

## Operation
- States: IDLE, ADDR, DATA, TURN.
- IDLE: if any m_req is high, pick the first requester at or after rr_ptr, cyclically. Register owner, m_ack, the command and beat count (len==0 -> 1). Go to ADDR.
- ADDR: s_req=1. On s_ack, go to DATA. The beat counter is loaded with the length.
- DATA: each cycle with s_wait=0 decrements the counter. When the last beat completes, go to TURN.
- TURN: one dead cycle; m_ack, s_req and busy are low. Set rr_ptr = owner+1 mod NUM_MASTERS, then go to IDLE.
- Command is latched at grant; master changes to addr/len during tenure are ignored.
- m_req dropped mid-tenure: ignored; the tenure runs to completion.
- No request in IDLE: stay; rr_ptr unchanged.
- Simultaneous requests: lowest index at or after rr_ptr wins. Every requester is served within NUM_MASTERS tenures.
- Reset (low at an edge) in any state: next state IDLE, rr_ptr=0, counters cleared. All outputs 0 after that edge: m_ack, s_req, s_write, s_burst_len, s_addr, owner, busy, err. An in-flight transfer is abandoned.

## Timing
- Request sampled in IDLE at edge N: m_ack, s_req and busy are high after edge N (one-cycle grant latency).
- s_ack sampled high at edge N+k: DATA starts at the next cycle.
- A burst of L beats with no wait takes 1 (IDLE) + ≥1 (ADDR) + L (DATA) + 1 (TURN) cycles.
- Back-to-back tenures are separated by TURN plus IDLE, giving a minimum of 2 cycles with m_ack all-zero.
- m_ack falls on the edge that completes the last beat.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A stall counter is cleared on each completed beat and on entering ADDR.
  - It counts cycles in ADDR with s_ack=0, or in DATA with s_wait=1.
  - When it reaches TIMEOUT_CYCLES: err pulses for 1 cycle, m_ack and s_req drop, and the FSM goes to TURN with rr_ptr advanced.
- ARB_TIMEOUT_EN undefined: no counter; err is constant 0; stalls wait forever.

## Structure
- Package bus_arb_pkg holds:
  - state enum arb_state_t (IDLE, ADDR, DATA, TURN)
  - burst-length-to-beats helper function (0 -> 1)
  - default parameter constants
- Sub-module rr_picker: combinational round-robin selector. Inputs are the request vector and rr_ptr. Outputs are a one-hot grant and its index. It is tested standalone.
- FSM, counters and command registers live in bus_arbiter.

## Test plan
- Single master 0, len=1, s_ack after 2 cycles, no waits -> m_ack=0001 for exactly 4 cycles, s_addr equals m_addr[0], then 1 TURN cycle.
- Masters 0..3 request simultaneously and hold, each len=2 -> grant order 0,1,2,3,0; each m_ack high 1+2 cycles (immediate s_ack).
- Master 2 has len=4 and s_wait is high on beats 2 and 3 for 3 cycles each -> tenure lasts 4+6 DATA cycles; no early m_ack release.
- Master 1 drops m_req and changes m_addr mid-burst -> s_addr is unchanged and the burst completes; with m_req low in TURN, master 1 is not regranted.
- Reset low during DATA of master 3 -> after that edge all outputs are 0 and state is IDLE. A new request from master 3 wins first (rr_ptr=0, only requester).
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, s_wait stuck high in DATA -> err pulses after 8 cycles, m_ack drops, and the next requester is granted.
